// File: rtl/calc_pkg.sv
// Shared types and key codes for the calculator entry path.
// Key codes come from grid_cursor; op_t values are what the external ALU decodes.
package calc_pkg;

    localparam logic [4:0] KEY_ADD = 5'h10;
    localparam logic [4:0] KEY_MUL = 5'h11;
    localparam logic [4:0] KEY_AND = 5'h12;
    localparam logic [4:0] KEY_EXE = 5'h13;
    localparam logic [4:0] KEY_SUB = 5'h14;
    localparam logic [4:0] KEY_OR  = 5'h15;
    localparam logic [4:0] KEY_CE  = 5'h16;
    localparam logic [4:0] KEY_CLR = 5'h17;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4
    } op_t;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_OP   = 3'd1,
        S_B    = 3'd2,
        S_EXEC = 3'd3,
        S_WAIT = 3'd4,
        S_SHOW = 3'd5
    } state_t;

endpackage

// File: rtl/calc_key_decode.sv
// Combinational classification of a 5-bit key code into digit / operator / control flags.
// Codes 0x18-0x1F raise no flag at all, so the controller ignores them.
module calc_key_decode
    import calc_pkg::*;
(
    input  logic [4:0] key_val,
    output logic       is_digit,
    output logic [3:0] digit,
    output logic       is_op,
    output op_t        op,
    output logic       is_exe,
    output logic       is_ce,
    output logic       is_clr
);

    always_comb begin
        is_digit = 1'b0;
        digit    = key_val[3:0];
        is_op    = 1'b0;
        op       = OP_ADD;
        is_exe   = 1'b0;
        is_ce    = 1'b0;
        is_clr   = 1'b0;
        if (!key_val[4]) begin
            is_digit = 1'b1;
        end else begin
            case (key_val)
                KEY_ADD: begin is_op = 1'b1; op = OP_ADD; end
                KEY_SUB: begin is_op = 1'b1; op = OP_SUB; end
                KEY_MUL: begin is_op = 1'b1; op = OP_MUL; end
                KEY_AND: begin is_op = 1'b1; op = OP_AND; end
                KEY_OR:  begin is_op = 1'b1; op = OP_OR;  end
                KEY_EXE: is_exe = 1'b1;
                KEY_CE:  is_ce  = 1'b1;
                KEY_CLR: is_clr = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/calc_entry_ctrl.sv
// Calculator entry controller: builds A, op and B from key presses, hands them to an
// external ALU over valid/ready, captures the result into A and drives the display value.
module calc_entry_ctrl
    import calc_pkg::*;
#(
    parameter  int DIGITS = 4,
    localparam int W      = 4 * DIGITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [4:0]   key_val,
    input  logic         key_press,
    output logic [W-1:0] op_a,
    output logic [W-1:0] op_b,
    output logic [2:0]   op_code,
    output logic         op_valid,
    input  logic         op_ready,
    input  logic         res_valid,
    input  logic [W-1:0] res_data,
    output logic         busy,
    output logic [W-1:0] disp_val,
    output logic [2:0]   state_o
);

    localparam int            CW       = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] DIGITS_C = CW'(DIGITS);

    state_t        state_q;
    logic [W-1:0]  a_q, b_q;
    logic [CW-1:0] cnt_a_q, cnt_b_q;
    op_t           op_q;
    logic          op_valid_q, busy_q;

    logic          is_digit, is_op, is_exe, is_ce, is_clr;
    logic [3:0]    digit;
    op_t           dec_op;
    logic [W-1:0]  a_shift_d, b_shift_d;

    calc_key_decode u_dec (
        .key_val  (key_val),
        .is_digit (is_digit),
        .digit    (digit),
        .is_op    (is_op),
        .op       (dec_op),
        .is_exe   (is_exe),
        .is_ce    (is_ce),
        .is_clr   (is_clr)
    );

    assign a_shift_d = {a_q[W-5:0], digit};
    assign b_shift_d = {b_q[W-5:0], digit};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_A;
            a_q        <= '0;
            b_q        <= '0;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
            op_q       <= OP_ADD;
            op_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                S_A: if (key_press) begin
                    if (is_digit) begin
                        if (cnt_a_q != DIGITS_C) begin
                            a_q     <= a_shift_d;
                            cnt_a_q <= cnt_a_q + CW'(1);
                        end
                    end else if (is_op) begin
                        op_q    <= dec_op;
                        state_q <= S_OP;
                    end else if (is_ce || is_clr) begin
                        a_q     <= '0;
                        cnt_a_q <= '0;
                    end
                end
                S_OP: if (key_press) begin
                    if (is_op) begin
                        op_q <= dec_op;
                    end else if (is_digit) begin
                        b_q     <= {{(W-4){1'b0}}, digit};
                        cnt_b_q <= CW'(1);
                        state_q <= S_B;
                    end else if (is_ce) begin
                        state_q <= S_A;
                    end else if (is_clr) begin
                        a_q     <= '0;
                        b_q     <= '0;
                        cnt_a_q <= '0;
                        cnt_b_q <= '0;
                        op_q    <= OP_ADD;
                        state_q <= S_A;
                    end
                end
                // Operator keys are deliberately ignored here: no chained expressions.
                S_B: if (key_press) begin
                    if (is_digit) begin
                        if (cnt_b_q != DIGITS_C) begin
                            b_q     <= b_shift_d;
                            cnt_b_q <= cnt_b_q + CW'(1);
                        end
                    end else if (is_exe) begin
                        state_q    <= S_EXEC;
                        op_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end else if (is_ce) begin
                        b_q     <= '0;
                        cnt_b_q <= '0;
                        state_q <= S_OP;
                    end else if (is_clr) begin
                        a_q     <= '0;
                        b_q     <= '0;
                        cnt_a_q <= '0;
                        cnt_b_q <= '0;
                        op_q    <= OP_ADD;
                        state_q <= S_A;
                    end
                end
                // A fast ALU may return its result on the accepting edge; skip S_WAIT then.
                S_EXEC: if (op_ready) begin
                    op_valid_q <= 1'b0;
                    if (res_valid) begin
                        a_q     <= res_data;
                        cnt_a_q <= '0;
                        state_q <= S_SHOW;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: if (res_valid) begin
                    a_q     <= res_data;
                    cnt_a_q <= '0;
                    state_q <= S_SHOW;
                    busy_q  <= 1'b0;
                end
                S_SHOW: if (key_press) begin
                    if (is_digit) begin
                        a_q     <= {{(W-4){1'b0}}, digit};
                        cnt_a_q <= CW'(1);
                        state_q <= S_A;
                    end else if (is_op) begin
                        op_q    <= dec_op;
                        state_q <= S_OP;
                    end else if (is_ce || is_clr) begin
                        a_q     <= '0;
                        cnt_a_q <= '0;
                        state_q <= S_A;
                    end
                end
                default: begin
                    state_q    <= S_A;
                    op_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign op_a     = a_q;
    assign op_b     = b_q;
    assign op_code  = op_q;
    assign op_valid = op_valid_q;
    assign busy     = busy_q;
    assign state_o  = state_q;
    assign disp_val = (state_q == S_B || state_q == S_EXEC || state_q == S_WAIT) ? b_q : a_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Self-checking bench for calc_entry_ctrl: directed vector table, hand-written ALU
// handshake sequences, then randomized traffic against a behavioural model.
module tb_calc_entry_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  key_val = '0;
    logic        key_press = 1'b0;
    logic [15:0] op_a, op_b, disp_val, res_data = '0;
    logic [2:0]  op_code, state_o;
    logic        op_valid, busy;
    logic        op_ready = 1'b0;
    logic        res_valid = 1'b0;

    int tests = 0;
    int fails = 0;

    calc_entry_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .key_val   (key_val),
        .key_press (key_press),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_code   (op_code),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .busy      (busy),
        .disp_val  (disp_val),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] k);
        key_val   = k;
        key_press = 1'b1;
        cycle();
        key_press = 1'b0;
    endtask

    // Behavioural model: modes numbered in the order the states are listed (A,OP,B,EXEC,WAIT,SHOW)
    int m_mode, m_na, m_nb, m_op;
    int m_a, m_b;

    function automatic int op_of_key(input int k);
        case (k)
            16: return 0;
            17: return 2;
            18: return 3;
            20: return 1;
            21: return 4;
            default: return -1;
        endcase
    endfunction

    function automatic void m_reset();
        m_mode = 0; m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_op = 0;
    endfunction

    function automatic void m_edge(input bit r, input bit kp, input int kv, input bit rdy,
                                   input bit rv, input int rd);
        bit dig, opk, exe, ce, clr;
        if (!r) begin
            m_reset();
            return;
        end
        if (m_mode == 3) begin
            if (rdy) begin
                if (rv) begin m_a = rd; m_na = 0; m_mode = 5; end
                else m_mode = 4;
            end
            return;
        end
        if (m_mode == 4) begin
            if (rv) begin m_a = rd; m_na = 0; m_mode = 5; end
            return;
        end
        if (!kp) return;
        dig = (kv < 16);
        opk = (op_of_key(kv) >= 0);
        exe = (kv == 19);
        ce  = (kv == 22);
        clr = (kv == 23);
        case (m_mode)
            0: begin
                if (dig && m_na < 4) begin m_a = (m_a * 16 + kv) % 65536; m_na++; end
                else if (opk) begin m_op = op_of_key(kv); m_mode = 1; end
                else if (ce || clr) begin m_a = 0; m_na = 0; end
            end
            1: begin
                if (opk) m_op = op_of_key(kv);
                else if (dig) begin m_b = kv; m_nb = 1; m_mode = 2; end
                else if (ce) m_mode = 0;
                else if (clr) m_reset();
            end
            2: begin
                if (dig && m_nb < 4) begin m_b = (m_b * 16 + kv) % 65536; m_nb++; end
                else if (exe) m_mode = 3;
                else if (ce) begin m_b = 0; m_nb = 0; m_mode = 1; end
                else if (clr) m_reset();
            end
            5: begin
                if (dig) begin m_a = kv; m_na = 1; m_mode = 0; end
                else if (opk) begin m_op = op_of_key(kv); m_mode = 1; end
                else if (ce || clr) begin m_a = 0; m_na = 0; m_mode = 0; end
            end
            default: ;
        endcase
        if (exe && m_mode != 3) return;
    endfunction

    typedef struct {
        logic [4:0]  key;
        logic [15:0] disp;
        logic [2:0]  st;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{5'h01, 16'h0001, 3'd0};
        vecs[1]  = '{5'h02, 16'h0012, 3'd0};
        vecs[2]  = '{5'h03, 16'h0123, 3'd0};
        vecs[3]  = '{5'h04, 16'h1234, 3'd0};
        vecs[4]  = '{5'h05, 16'h1234, 3'd0};
        vecs[5]  = '{5'h16, 16'h0000, 3'd0};
        vecs[6]  = '{5'h01, 16'h0001, 3'd0};
        vecs[7]  = '{5'h02, 16'h0012, 3'd0};
        vecs[8]  = '{5'h10, 16'h0012, 3'd1};
        vecs[9]  = '{5'h03, 16'h0003, 3'd2};
        vecs[10] = '{5'h04, 16'h0034, 3'd2};
        vecs[11] = '{5'h13, 16'h0034, 3'd3};

        // Reset state
        rst = 1'b0;
        cycle(); cycle();
        check("reset_state", 32'(state_o), 32'd0);
        check("reset_disp", 32'(disp_val), 32'd0);
        check("reset_valid", 32'(op_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_opcode", 32'(op_code), 32'd0);
        rst = 1'b1;

        // Digit entry, overflow drop, CE, then build A + B and execute
        for (int i = 0; i < 12; i++) begin
            press(vecs[i].key);
            $display("[TB] vec %0d key=0x%0h disp=0x%0h state=%0d", i, vecs[i].key, disp_val, state_o);
            check($sformatf("vec%0d_disp", i), 32'(disp_val), 32'(vecs[i].disp));
            check($sformatf("vec%0d_state", i), 32'(state_o), 32'(vecs[i].st));
        end
        check("exec_valid", 32'(op_valid), 32'd1);
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_op_a", 32'(op_a), 32'h0012);
        check("exec_op_b", 32'(op_b), 32'h0034);
        check("exec_opcode", 32'(op_code), 32'd0);

        // ALU stalls for 3 cycles; request must hold steady
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_valid", 32'(op_valid), 32'd1);
            check("stall_op_a", 32'(op_a), 32'h0012);
            check("stall_op_b", 32'(op_b), 32'h0034);
            check("stall_state", 32'(state_o), 32'd3);
        end
        op_ready = 1'b1;
        cycle();
        op_ready = 1'b0;
        check("wait_state", 32'(state_o), 32'd4);
        check("wait_valid", 32'(op_valid), 32'd0);
        check("wait_busy", 32'(busy), 32'd1);
        res_valid = 1'b1; res_data = 16'h0046;
        cycle();
        res_valid = 1'b0;
        $display("[TB] result 0x0046 -> disp=0x%0h state=%0d", disp_val, state_o);
        check("show_state", 32'(state_o), 32'd5);
        check("show_disp", 32'(disp_val), 32'h0046);
        check("show_busy", 32'(busy), 32'd0);

        // Chain from result: SUB 6, ALU answers on the accepting edge
        press(5'h14);
        check("chain_state_op", 32'(state_o), 32'd1);
        press(5'h06);
        press(5'h13);
        check("chain_op_a", 32'(op_a), 32'h0046);
        check("chain_op_b", 32'(op_b), 32'h0006);
        check("chain_opcode", 32'(op_code), 32'd1);
        op_ready = 1'b1; res_valid = 1'b1; res_data = 16'h0040;
        cycle();
        op_ready = 1'b0; res_valid = 1'b0;
        $display("[TB] fast result 0x0040 -> disp=0x%0h state=%0d", disp_val, state_o);
        check("fast_state", 32'(state_o), 32'd5);
        check("fast_disp", 32'(disp_val), 32'h0040);
        check("fast_valid", 32'(op_valid), 32'd0);

        // CE and CLR inside S_B
        press(5'h07);
        check("show_digit_state", 32'(state_o), 32'd0);
        check("show_digit_disp", 32'(disp_val), 32'h0007);
        press(5'h11);
        press(5'h07);
        press(5'h08);
        check("b_disp", 32'(disp_val), 32'h0078);
        press(5'h10);
        check("b_opkey_ignored", 32'(state_o), 32'd2);
        press(5'h16);
        check("ce_b_state", 32'(state_o), 32'd1);
        check("ce_b_disp", 32'(disp_val), 32'h0007);
        check("ce_b_op_b", 32'(op_b), 32'd0);
        press(5'h07);
        press(5'h08);
        press(5'h17);
        $display("[TB] CLR in S_B -> disp=0x%0h state=%0d op=%0d", disp_val, state_o, op_code);
        check("clr_state", 32'(state_o), 32'd0);
        check("clr_disp", 32'(disp_val), 32'd0);
        check("clr_op_b", 32'(op_b), 32'd0);
        check("clr_opcode", 32'(op_code), 32'd0);

        // Keys during S_WAIT are ignored, CLR included
        press(5'h01); press(5'h12); press(5'h02); press(5'h13);
        op_ready = 1'b1;
        cycle();
        op_ready = 1'b0;
        press(5'h17);
        check("wait_clr_state", 32'(state_o), 32'd4);
        check("wait_clr_busy", 32'(busy), 32'd1);
        check("wait_clr_op_a", 32'(op_a), 32'h0001);
        res_valid = 1'b1; res_data = 16'h0000;
        cycle();
        res_valid = 1'b0;
        check("wait_done_state", 32'(state_o), 32'd5);

        // Reset while the request is outstanding
        press(5'h05); press(5'h10); press(5'h05); press(5'h13);
        check("pre_rst_valid", 32'(op_valid), 32'd1);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        check("midrst_valid", 32'(op_valid), 32'd0);
        check("midrst_state", 32'(state_o), 32'd0);
        res_valid = 1'b1; res_data = 16'h0099;
        cycle();
        res_valid = 1'b0;
        $display("[TB] stray result after reset -> disp=0x%0h state=%0d", disp_val, state_o);
        check("stray_res_disp", 32'(disp_val), 32'd0);
        check("stray_res_op_a", 32'(op_a), 32'd0);

        // Randomized traffic against the model
        rst = 1'b0;
        m_reset();
        cycle();
        for (int i = 0; i < 3000; i++) begin
            int exp_disp;
            rst       = ($urandom_range(99) != 0);
            key_press = $urandom_range(1);
            key_val   = 5'($urandom_range(31));
            op_ready  = ($urandom_range(2) == 0);
            res_valid = ($urandom_range(2) == 0);
            res_data  = 16'($urandom);
            m_edge(rst, key_press, int'(key_val), op_ready, res_valid, int'(res_data));
            cycle();
            exp_disp = (m_mode == 2 || m_mode == 3 || m_mode == 4) ? m_b : m_a;
            check("rnd_state", 32'(state_o), 32'(m_mode));
            check("rnd_disp", 32'(disp_val), 32'(exp_disp));
            check("rnd_op_a", 32'(op_a), 32'(m_a));
            check("rnd_op_b", 32'(op_b), 32'(m_b));
            check("rnd_opcode", 32'(op_code), 32'(m_op));
            check("rnd_valid", 32'(op_valid), 32'(m_mode == 3));
            check("rnd_busy", 32'(busy), 32'(m_mode == 3 || m_mode == 4));
        end
        key_press = 1'b0;
        rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
